serial_adder_ctrl: RTL and testbench

Bit-serial multi-bit adder controller that time-shares one single-bit full-adder cell across a WIDTH-bit addition. It accepts a start request with two operands and a carry-in, then runs one bit per clock, LSB first, through the cell. A registered carry feeds each bit into the next. It returns a WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits between a requesting sequencer and the 1-bit adder datapath, trading latency for area.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/fa_bit.sv | 13 +
 rtl/serial_adder_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// Used by serial_adder_ctrl (optional ovf output under SERIAL_ADD_OVF_EN).
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width; clamps to 1 so degenerate widths still elaborate.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fa_bit.sv
// Combinational 1-bit full adder cell, time-shared by the serial controller.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per clock.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_next;
  logic             load;
  logic             last_bit;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cell_s, cell_c;

  fa_bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (cell_s),
    .cout (cell_c)
  );

  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Start is only honoured in IDLE or DONE; SHIFT ignores it entirely.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status flags track the state being entered so they stay pure flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == SHIFT);
      done <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == SHIFT) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      sum   <= {cell_s, sum[WIDTH-1:1]};
      carry <= cell_c;
      // Counter parks on the last value instead of wrapping.
      if (last_bit) cout <= cell_c;
      else          cnt  <= cnt + 1'b1;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // On the MSB step, carry holds the carry into the MSB and cell_c the carry out.
  always_ff @(posedge clk) begin
    if (rst || load)                      ovf <= 1'b0;
    else if (state == SHIFT && last_bit)  ovf <= carry ^ cell_c;
  end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
// Checks ovf as well when built with SERIAL_ADD_OVF_EN.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  logic expOvf;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; sampling and driving happen 1ns later.
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Present one request for a single edge, then scramble the operand inputs.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic cv);
    logic [WIDTH-1:0] s9;
    s9     = av + bv + {{(WIDTH-1){1'b0}}, cv};
    expOvf = (av[WIDTH-1] == bv[WIDTH-1]) && (s9[WIDTH-1] != av[WIDTH-1]);
    a = av; b = bv; cin = cv; start = 1'b1;
    stepClk();
    start = 1'b0;
    a = 8'hE7; b = 8'h3D; cin = ~cv;
    checkOutput("load_busy", busy, 1);
    checkOutput("load_done", done, 0);
    checkOutput("load_sum_clr", sum, 0);
    checkOutput("load_cout_clr", cout, 0);
  endtask

  // Runs the remaining bit steps; injectAt>0 pulses a stray start in that cycle.
  task automatic waitDone(input string tag, input logic [WIDTH-1:0] es, input logic ec,
                          input int injectAt);
    int busyCycles = 1;
    int early = 0;
    for (int i = 1; i < WIDTH; i++) begin
      if (i == injectAt) begin
        start = 1'b1; a = 8'hAA; b = 8'hAA; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      stepClk();
      if (busy) busyCycles++;
      if (done) early++;
    end
    start = 1'b0;
    stepClk();
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_sum"}, sum, es);
    checkOutput({tag, "_cout"}, cout, ec);
    checkOutput({tag, "_busycycles"}, busyCycles, WIDTH);
    checkOutput({tag, "_early"}, early, 0);
`ifdef SERIAL_ADD_OVF_EN
    checkOutput({tag, "_ovf"}, ovf, expOvf);
`endif
  endtask

  initial begin
    int changed;
    int seen;
    logic [WIDTH:0] r;
    logic [WIDTH-1:0] ra, rb;
    logic rc;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; expOvf = 1'b0;
    stepClk();
    stepClk();
    rst = 1'b0;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_cout", cout, 0);

    applyStimulus(8'h5A, 8'h3C, 1'b0);
    waitDone("add5a3c", 8'h96, 1'b0, -1);
    stepClk();
    checkOutput("done_pulse_end", done, 0);
    checkOutput("idle_busy", busy, 0);
    changed = 0;
    for (int i = 0; i < 20; i++) begin
      stepClk();
      if (sum !== 8'h96 || cout !== 1'b0 || done !== 1'b0) changed++;
    end
    checkOutput("hold20", changed, 0);

    applyStimulus(8'hFF, 8'h01, 1'b0);
    waitDone("addff01", 8'h00, 1'b1, -1);
    stepClk();
    applyStimulus(8'h00, 8'h00, 1'b1);
    waitDone("cin_only", 8'h01, 1'b0, -1);
    stepClk();

    // Stray start mid-operation, then a start held in DONE.
    applyStimulus(8'h12, 8'h34, 1'b1);
    waitDone("ignore_start", 8'h47, 1'b0, 3);
    applyStimulus(8'hC8, 8'h64, 1'b0);
    waitDone("backtoback", 8'h2C, 1'b1, -1);
    stepClk();

    // Reset in the middle of an operation.
    applyStimulus(8'h0F, 8'h01, 1'b0);
    stepClk(); stepClk(); stepClk();
    rst = 1'b1;
    stepClk();
    rst = 1'b0;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_sum", sum, 0);
    checkOutput("midrst_cout", cout, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      stepClk();
      if (done || busy) seen++;
    end
    checkOutput("midrst_quiet", seen, 0);
    applyStimulus(8'h80, 8'h80, 1'b1);
    waitDone("after_rst", 8'h01, 1'b1, -1);
    stepClk();

`ifdef SERIAL_ADD_OVF_EN
    applyStimulus(8'h7F, 8'h01, 1'b0);
    waitDone("ovf7f01", 8'h80, 1'b0, -1);
    checkOutput("ovf7f01_hand", ovf, 1);
    stepClk();
    applyStimulus(8'h80, 8'hFF, 1'b0);
    waitDone("ovf80ff", 8'h7F, 1'b1, -1);
    checkOutput("ovf80ff_hand", ovf, 1);
    stepClk();
    applyStimulus(8'h10, 8'h20, 1'b0);
    waitDone("ovf1020", 8'h30, 1'b0, -1);
    checkOutput("ovf1020_hand", ovf, 0);
    stepClk();
`endif

    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      r  = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      applyStimulus(ra, rb, rc);
      waitDone("rand", r[WIDTH-1:0], r[WIDTH], -1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
